// File: rtl/mem_c_data_buffer.sv
// Ping-pong buffer for result tiles. Each tile is drained as a stream of bus words,
// row-major within each column chunk.
module mem_c_data_buffer #(
  parameter int unsigned BUS_WIDTH_BYTES  = 32,
  parameter int unsigned DATA_WIDTH_BYTES = 2,
  parameter int unsigned ARRAY_HEIGHT     = 4,
  parameter int unsigned ARRAY_WIDTH      = 32
) (
  input  logic                                                  clk,
  input  logic                                                  reset_n,
  input  logic                                                  clear_i,
  input  logic                                                  tile_valid_i,
  input  logic [ARRAY_HEIGHT*ARRAY_WIDTH*DATA_WIDTH_BYTES*8-1:0] tile_data_i,
  output logic                                                  tile_ready_o,
  output logic                                                  fifo_empty,
  input  logic                                                  fifo_incr,
  output logic [BUS_WIDTH_BYTES*8-1:0]                          data_o
);

  localparam int unsigned DW       = 8 * DATA_WIDTH_BYTES;
  localparam int unsigned COL_STEP = BUS_WIDTH_BYTES / DATA_WIDTH_BYTES;
  localparam int unsigned WORDS    = ARRAY_HEIGHT * ARRAY_WIDTH / COL_STEP;
  localparam int unsigned TILE_W   = ARRAY_HEIGHT * ARRAY_WIDTH * DW;
  localparam int unsigned BUS_W    = BUS_WIDTH_BYTES * 8;
  localparam int unsigned WORD_W   = (WORDS > 1) ? $clog2(WORDS) : 1;

  if ((BUS_WIDTH_BYTES % DATA_WIDTH_BYTES) != 0 || (ARRAY_WIDTH % COL_STEP) != 0) begin : gen_chk
    $error("mem_c_data_buffer: bus width must hold a whole number of element columns");
  end

  logic [TILE_W-1:0] bank_q [2];
  logic [TILE_W-1:0] bank_d [2];
  logic [1:0]        full_q, full_d;
  logic              wr_sel_q, wr_sel_d;
  logic              rd_sel_q, rd_sel_d;
  logic [WORD_W-1:0] rd_word_q, rd_word_d;

  logic accept;
  logic pop;

  assign tile_ready_o = ~full_q[wr_sel_q];
  assign fifo_empty   = ~full_q[rd_sel_q];
  assign accept       = tile_valid_i & tile_ready_o;
  assign pop          = fifo_incr & ~fifo_empty;

  // The COL_STEP lanes of one word are adjacent columns of one row, hence contiguous bits.
  always_comb begin
    int unsigned chunk;
    int unsigned row;
    int unsigned base;
    chunk  = 32'(rd_word_q) / ARRAY_HEIGHT;
    row    = 32'(rd_word_q) % ARRAY_HEIGHT;
    base   = (row * ARRAY_WIDTH + chunk * COL_STEP) * DW;
    data_o = bank_q[rd_sel_q][base +: BUS_W];
  end

  always_comb begin
    bank_d    = bank_q;
    full_d    = full_q;
    wr_sel_d  = wr_sel_q;
    rd_sel_d  = rd_sel_q;
    rd_word_d = rd_word_q;
    if (clear_i) begin
      full_d    = '0;
      wr_sel_d  = 1'b0;
      rd_sel_d  = 1'b0;
      rd_word_d = '0;
    end else begin
      // Accept and release always target different banks: one needs empty, the other full.
      if (pop) begin
        if (rd_word_q == WORD_W'(WORDS - 1)) begin
          rd_word_d          = '0;
          full_d[rd_sel_q]   = 1'b0;
          rd_sel_d           = ~rd_sel_q;
        end else begin
          rd_word_d = rd_word_q + WORD_W'(1);
        end
      end
      if (accept) begin
        bank_d[wr_sel_q] = tile_data_i;
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = ~wr_sel_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_q[0] <= '0;
      bank_q[1] <= '0;
      full_q    <= '0;
      wr_sel_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
      rd_word_q <= '0;
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      full_q    <= full_d;
      wr_sel_q  <= wr_sel_d;
      rd_sel_q  <= rd_sel_d;
      rd_word_q <= rd_word_d;
    end
  end

endmodule

// File: doc/mem_c_data_buffer.md
MEM_C_DATA_BUFFER -- requirements
Module: mem_c_data_buffer

Interface
REQ-001 SHALL have parameter BUS_WIDTH_BYTES, default 32, meaning the write-bus word width in bytes.
REQ-002 SHALL have parameter DATA_WIDTH_BYTES, default 2, meaning the C element width in bytes; DW = 8*DATA_WIDTH_BYTES.
REQ-003 SHALL have parameter ARRAY_HEIGHT, default 4, meaning the result-tile rows.
REQ-004 SHALL have parameter ARRAY_WIDTH, default 32, meaning the result-tile columns.
REQ-005 SHALL derive COL_STEP = BUS_WIDTH_BYTES/DATA_WIDTH_BYTES and WORDS = ARRAY_HEIGHT*ARRAY_WIDTH/COL_STEP (8 at defaults).
REQ-006 SHALL use clk and reset_n: reset reset_n, asynchronous, active-low; clock clk.
REQ-007 SHALL have ports, in this order:
- clk  in  1  rising-edge clock
- reset_n  in  1  async active-low reset
- clear_i  in  1  synchronous flush; pulsed at job start
- tile_valid_i  in  1  array offers a finished result tile
- tile_data_i  in  ARRAY_HEIGHT*ARRAY_WIDTH*DW  element (r,c) at bits [(r*ARRAY_WIDTH+c)*DW +: DW]
- tile_ready_o  out  1  buffer can accept a tile this cycle
- fifo_empty  out  1  no bus word available to the C address generator
- fifo_incr  in  1  address generator consumed current word
- data_o  out  BUS_WIDTH_BYTES*8  current bus word

Function
REQ-008 SHALL hold two tile banks (ping-pong), each with a registered full flag; write pointer wr_sel, read pointer rd_sel, word counter rd_word (0..WORDS-1).
REQ-009 SHALL drive tile_ready_o = ~full[wr_sel], purely from registers.
REQ-010 SHALL accept a tile when tile_valid_i & tile_ready_o at a rising edge: store tile_data_i into bank[wr_sel], set full[wr_sel], toggle wr_sel.
REQ-011 SHALL drive fifo_empty = ~full[rd_sel], so the first word is visible the cycle after acceptance (1-cycle latency).
REQ-012 SHALL present word k = rd_word with chunk = k / ARRAY_HEIGHT and row = k % ARRAY_HEIGHT; data_o lane j (bits [j*DW +: DW], j = 0..COL_STEP-1) = element(row, chunk*COL_STEP + j) of bank[rd_sel].
REQ-013 SHALL drive data_o combinationally from registered state; data_o is don't-care while fifo_empty = 1.
REQ-014 SHALL, on fifo_incr & ~fifo_empty, increment rd_word; if rd_word == WORDS-1, instead set rd_word to 0, clear full[rd_sel] and toggle rd_sel.
REQ-015 SHALL ignore fifo_incr while fifo_empty = 1, with no state change.
REQ-016 SHALL perform an accept into one bank and a final-word release of the other bank in the same cycle, both taking effect.
REQ-017 SHALL never accept into a full bank; tile_valid_i while tile_ready_o = 0 has no effect, and the source holds the tile.
REQ-018 SHALL treat clear_i as highest priority: clear both full flags, wr_sel, rd_sel and rd_word to 0, and ignore a same-cycle accept or fifo_incr.
REQ-019 SHALL require BUS_WIDTH_BYTES % DATA_WIDTH_BYTES == 0 and ARRAY_WIDTH % COL_STEP == 0, flagged by an elaboration-time check.

Reset
REQ-020 SHALL on reset_n low set full flags = 0, wr_sel = 0, rd_sel = 0, rd_word = 0 and bank contents = 0, giving tile_ready_o = 1, fifo_empty = 1 and data_o = 0.
REQ-021 SHALL discard any partially drained tile on reset mid-operation; the first word after reset comes from the next accepted tile.

Verification
REQ-022 Reset: assert reset_n = 0 mid-drain -> tile_ready_o = 1, fifo_empty = 1 and data_o = 0 immediately; fifo_incr pulses after release cause no change.
REQ-023 Ordering: element(r,c) = r*256+c, one tile, 8 fifo_incr pulses -> lane j of word 0 = 0x0000+j, word 1 = 0x0100+j, word 3 = 0x0300+j, word 4 = 0x0010+j, word 7 = 0x0310+j; fifo_empty = 1 after the 8th pulse.
REQ-024 Backpressure: present three tiles back-to-back -> two accepted, tile_ready_o = 0; tile_ready_o rises the cycle after the 8th fifo_incr of tile 0, then tile 2 is accepted.
REQ-025 Simultaneous: tile_valid_i into empty bank 1 in the same cycle as the final fifo_incr of bank 0 -> next cycle fifo_empty = 0 and data_o = word 0 of the new tile.
REQ-026 Empty incr: fifo_incr = 1 for 5 cycles with no tile, then one tile -> data_o = word 0 (rd_word not advanced).
REQ-027 Clear: clear_i after 3 of 8 words with a second tile pending -> next cycle fifo_empty = 1 and tile_ready_o = 1; the next tile drains from word 0.
